// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, drain FSM encoding and accumulator limiting for the PE row
package pe_pkg;

    localparam int ACC_MAXW = 64;
    localparam int WIDE_W   = ACC_MAXW + 2;

    typedef logic signed [WIDE_W-1:0] wide_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CAPT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // The sum is computed with headroom; clamping happens here, wrapping is the caller's truncation.
    function automatic wide_t acc_limit(input wide_t sum, input int aw, input logic sat, input logic sgn);
        wide_t one;
        wide_t vmax;
        wide_t vmin;
        one = wide_t'(1);
        if (sgn) begin
            vmax = (one <<< (aw - 1)) - one;
            vmin = -(one <<< (aw - 1));
        end else begin
            vmax = (one <<< aw) - one;
            vmin = '0;
        end
        acc_limit = sum;
        if (sat) begin
            if (sum > vmax)
                acc_limit = vmax;
            else if (sum < vmin)
                acc_limit = vmin;
        end
    endfunction

endpackage

// File: rtl/pe_row_stream_cell.sv
// rtl/pe_row_stream_cell.sv - one MAC lane: operand forwarding, B delay, accumulator and shadow
module pe_mac_cell
    import pe_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int ACC_WIDTH   = 20,
    parameter int SIGNED_MODE = 1,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BITWIDTH-1:0]  i_a,
    input  logic                 i_v,
    input  logic                 i_f,
    input  logic                 i_l,
    input  logic [BITWIDTH-1:0]  i_b,
    output logic [BITWIDTH-1:0]  o_a,
    output logic                 o_v,
    output logic                 o_f,
    output logic                 o_l,
    output logic [BITWIDTH-1:0]  o_b,
    output logic [ACC_WIDTH-1:0] o_shadow
);

    localparam logic SGN = (SIGNED_MODE != 0);
    localparam logic SAT = (SATURATE != 0);

    logic [BITWIDTH-1:0]   r_a, r_b;
    logic                  r_v, r_f, r_l;
    logic [ACC_WIDTH-1:0]  r_acc, r_shadow;
    logic [2*BITWIDTH-1:0] w_ea, w_eb, w_prod;
    logic [ACC_WIDTH-1:0]  w_base, w_next;
    wide_t                 w_sum;

    // Low 2*BITWIDTH bits of the product of extended operands are correct for both signednesses.
    assign w_ea   = {{BITWIDTH{SGN & i_a[BITWIDTH-1]}}, i_a};
    assign w_eb   = {{BITWIDTH{SGN & i_b[BITWIDTH-1]}}, i_b};
    assign w_prod = w_ea * w_eb;
    assign w_base = i_f ? '0 : r_acc;
    assign w_sum  = {{(WIDE_W-ACC_WIDTH){SGN & w_base[ACC_WIDTH-1]}}, w_base}
                  + {{(WIDE_W-2*BITWIDTH){SGN & w_prod[2*BITWIDTH-1]}}, w_prod};
    assign w_next = ACC_WIDTH'(acc_limit(w_sum, ACC_WIDTH, SAT, SGN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_v      <= 1'b0;
            r_f      <= 1'b0;
            r_l      <= 1'b0;
            r_acc    <= '0;
            r_shadow <= '0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
            r_v <= i_v;
            r_f <= i_f;
            r_l <= i_l;
            if (i_v) begin
                r_acc <= w_next;
                if (i_l)
                    r_shadow <= w_next;
            end
        end
    end

    assign o_a      = r_a;
    assign o_v      = r_v;
    assign o_f      = r_f;
    assign o_l      = r_l;
    assign o_b      = r_b;
    assign o_shadow = r_shadow;

endmodule

// File: rtl/pe_row_stream.sv
// rtl/pe_row_stream.sv - systolic PE row with tile protocol and serial result drain
module pe_row_stream
    import pe_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int Y_COL       = 3,
    parameter int ACC_WIDTH   = 20,
    parameter int SIGNED_MODE = 1,
    parameter int SATURATE    = 0,
    parameter int IDX_W       = (Y_COL > 1) ? $clog2(Y_COL) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [BITWIDTH-1:0]       in_row,
    input  logic [Y_COL*BITWIDTH-1:0] in_col,
    output logic [Y_COL*BITWIDTH-1:0] out_col,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_WIDTH-1:0]      res_data,
    output logic [IDX_W-1:0]          res_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Y_COL - 1);

    logic [BITWIDTH-1:0]  w_a [Y_COL+1];
    logic                 w_v [Y_COL+1];
    logic                 w_f [Y_COL+1];
    logic                 w_l [Y_COL+1];
    logic [ACC_WIDTH-1:0] w_shadow [2**IDX_W];

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             w_busy, w_snap0, w_snap_last, w_hs;

    assign w_a[0] = in_row;
    assign w_v[0] = in_valid & in_ready;
    assign w_f[0] = in_first;
    assign w_l[0] = in_last;

    genvar gi;
    generate
        for (gi = 0; gi < Y_COL; gi++) begin : g_lane
            pe_mac_cell #(
                .BITWIDTH    (BITWIDTH),
                .ACC_WIDTH   (ACC_WIDTH),
                .SIGNED_MODE (SIGNED_MODE),
                .SATURATE    (SATURATE)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_a      (w_a[gi]),
                .i_v      (w_v[gi]),
                .i_f      (w_f[gi]),
                .i_l      (w_l[gi]),
                .i_b      (in_col[(Y_COL-1-gi)*BITWIDTH +: BITWIDTH]),
                .o_a      (w_a[gi+1]),
                .o_v      (w_v[gi+1]),
                .o_f      (w_f[gi+1]),
                .o_l      (w_l[gi+1]),
                .o_b      (out_col[(Y_COL-1-gi)*BITWIDTH +: BITWIDTH]),
                .o_shadow (w_shadow[gi])
            );
        end
        for (gi = Y_COL; gi < 2**IDX_W; gi++) begin : g_pad
            assign w_shadow[gi] = '0;
        end
    endgenerate

    // Only a last beat is held back while the shadows are still owed to the consumer.
    assign w_busy      = (r_state != ST_IDLE);
    assign in_ready    = ~(w_busy & in_last);
    assign w_snap0     = w_v[0] & w_l[0];
    assign w_snap_last = w_v[Y_COL-1] & w_l[Y_COL-1];
    assign w_hs        = res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_snap0)
                        r_state <= (Y_COL == 1) ? ST_DRAIN : ST_CAPT;
                end
                ST_CAPT: begin
                    if (w_snap_last)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == ST_DRAIN);
    assign res_data  = w_shadow[r_idx];
    assign res_idx   = r_idx;

endmodule
